// File: rtl/nn_weights_pkg.sv
// Shared types and LFSR helpers for the weight initialisation sequencer.
package nn_weights_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // 16-bit Galois step: shift right, fold the mask in when the lsb falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] shifted;
    shifted = {1'b0, s[15:1]};
    lfsr_next = s[0] ? (shifted ^ LFSR_MASK) : shifted;
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  function automatic logic [15:0] fix_seed(input logic [15:0] seed);
    fix_seed = (seed == 16'h0000) ? DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/lfsr_weight_source.sv
// Pseudo-random weight source: LFSR register that reloads its seed on reset
// and advances only when stepped.
module lfsr_weight_source
  import nn_weights_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_r;

  // LFSR state register; reset takes priority over a pending step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= fix_seed(SEED);
    end else if (step) begin
      state_r <= lfsr_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/weight_init_sequencer.sv
// Fills a rows x columns weight memory in row-major order from an LFSR.
// Optional WEIGHT_SCALE_EN adds scale_shift to arithmetically shrink weights.
module weight_init_sequencer
  import nn_weights_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter int          DIM_W  = 8,
  parameter int          ADDR_W = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  no_of_rows,
  input  logic [DIM_W-1:0]  no_of_columns,
`ifdef WEIGHT_SCALE_EN
  input  logic [3:0]        scale_shift,
`endif
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  seq_state_e        state_r, state_s;
  logic [DIM_W-1:0]  rows_r, cols_r, row_r, col_r;
  logic [ADDR_W-1:0] addr_r;
  logic              wr_valid_r, busy_r, done_r;
  logic              xfer_s, last_s, zero_dim_s;
  logic [15:0]       lfsr_s, data_s;

  assign xfer_s     = wr_valid_r & wr_ready;
  assign last_s     = (row_r == rows_r - DIM_W'(1)) && (col_r == cols_r - DIM_W'(1));
  assign zero_dim_s = (rows_r == {DIM_W{1'b0}}) || (cols_r == {DIM_W{1'b0}});

  lfsr_weight_source #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (xfer_s),
    .state (lfsr_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start is only honoured in IDLE and never queued.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = LOAD;
        else       state_s = IDLE;
      end
      LOAD: begin
        if (zero_dim_s) state_s = DONE;
        else            state_s = RUN;
      end
      RUN: begin
        if (xfer_s && last_s) state_s = DONE;
        else                  state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Status outputs are registered from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      wr_valid_r <= (state_s == RUN);
      busy_r     <= (state_s == LOAD) || (state_s == RUN);
      done_r     <= (state_s == DONE);
    end
  end

  // Dimension latch and row/column/address counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_r <= {DIM_W{1'b0}};
      cols_r <= {DIM_W{1'b0}};
      row_r  <= {DIM_W{1'b0}};
      col_r  <= {DIM_W{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else if (state_r == IDLE && start) begin
      rows_r <= no_of_rows;
      cols_r <= no_of_columns;
    end else if (state_r == LOAD) begin
      row_r  <= {DIM_W{1'b0}};
      col_r  <= {DIM_W{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else if (state_r == RUN && xfer_s) begin
      addr_r <= addr_r + ADDR_W'(1);
      if (col_r == cols_r - DIM_W'(1)) begin
        col_r <= {DIM_W{1'b0}};
        row_r <= row_r + DIM_W'(1);
      end else begin
        col_r <= col_r + DIM_W'(1);
      end
    end else begin
      addr_r <= addr_r;
    end
  end

`ifdef WEIGHT_SCALE_EN
  logic [3:0] shift_r;

  // Scale shift is captured together with the dimensions.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= 4'd0;
    end else if (state_r == IDLE && start) begin
      shift_r <= scale_shift;
    end else begin
      shift_r <= shift_r;
    end
  end

  assign data_s = 16'($signed(lfsr_s) >>> shift_r);
`else
  assign data_s = lfsr_s;
`endif

  // Data is forced to zero outside RUN so idle outputs stay quiet.
  assign wr_valid = wr_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign wr_addr  = addr_r;
  assign wr_data  = wr_valid_r ? DATA_W'(data_s) : {DATA_W{1'b0}};

endmodule

// File: tb/tb_weight_init_sequencer.sv
// Self-checking bench for weight_init_sequencer: run table plus scoreboard of
// expected (addr, data) writes.
module tb_weight_init_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, wr_ready, wr_valid, busy, done;
  logic [7:0]  no_of_rows, no_of_columns;
  logic [15:0] wr_addr, wr_data;
  logic [3:0]  scale_shift;

  always #5 clk = ~clk;

  weight_init_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .no_of_rows    (no_of_rows),
    .no_of_columns (no_of_columns),
`ifdef WEIGHT_SCALE_EN
    .scale_shift   (scale_shift),
`endif
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done)
  );

  // mode 0 = always ready, 1 = ready pattern 1,0,0 repeating from first RUN cycle
  typedef struct {
    int rows;
    int cols;
    int mode;
    int start_at;
    int rst_at;
    int shift;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  vec_t        vecs[8];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer;
  logic [15:0] model_lfsr;
  logic [15:0] first_d[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] s);
    logic [15:0] h;
    h = s >> 1;
    if (s[0]) return h ^ 16'hB400;
    return h;
  endfunction

  function automatic logic [15:0] m_data(input logic [15:0] s, input int sh);
`ifdef WEIGHT_SCALE_EN
    return 16'($signed(s) >>> sh);
`else
    return s;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    int   done_idx = -1;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   first_valid = -1;
    int   exp_n;
    bit   stalled = 1'b0;
    logic [15:0] sa, sd;
    exp_t e;
    exp_n = v.rows * v.cols;
    for (int r = 0; r < v.rows; r++) begin
      for (int c = 0; c < v.cols; c++) begin
        sb.push_back('{addr: 16'(r * v.cols + c), data: m_data(model_lfsr, v.shift)});
        model_lfsr = m_next(model_lfsr);
      end
    end
    n_xfer        = 0;
    no_of_rows    = 8'(v.rows);
    no_of_columns = 8'(v.cols);
    scale_shift   = 4'(v.shift);
    start         = 1'b1;
    wr_ready      = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      start    = (i == v.start_at);
      rst      = (i == v.rst_at);
      wr_ready = (v.mode == 0) ? 1'b1 : ((i % 3) == 2);
      if (busy) busy_cnt++;
      if (wr_valid && first_valid < 0) first_valid = i;
      if (stalled) begin
        check("stall_valid", 32'(wr_valid), 32'd1);
        check("stall_addr", 32'(wr_addr), 32'(sa));
        check("stall_data", 32'(wr_data), 32'(sd));
      end
      stalled = wr_valid && !wr_ready && !rst;
      sa = wr_addr;
      sd = wr_data;
      if (wr_valid && wr_ready && !rst) begin
        if (sb.size() == 0) begin
          check("extra_write", 32'(wr_addr), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
        end
        if (n_xfer < 2) first_d[n_xfer] = wr_data;
        n_xfer++;
      end
      if (done_idx > 0 && i > done_idx)
        check("idle_after_done", 32'({busy, wr_valid, done}), 32'd0);
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      tick();
      if (v.rst_at == i) begin
        rst = 1'b0;
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        model_lfsr = 16'hACE1;
        sb.delete();
        for (int k = 0; k < 6; k++) begin
          check("rst_no_done", 32'({done, wr_valid}), 32'd0);
          tick();
        end
        return;
      end
      if (done_idx > 0 && i >= done_idx + 2) break;
    end
    if (done_idx < 0) begin
      check("timeout_no_done", 32'd0, 32'd1);
    end else begin
      check("done_count", 32'(done_cnt), 32'd1);
      check("busy_cycles", 32'(busy_cnt), 32'(done_idx - 1));
      if (v.mode == 0) check("done_latency", 32'(done_idx), 32'(exp_n + 2));
    end
    check("xfer_count", 32'(n_xfer), 32'(exp_n));
    check("sb_empty", 32'(sb.size()), 32'd0);
    if (exp_n == 0) check("no_valid_zero_dim", 32'(first_valid), 32'hFFFF_FFFF);
    else            check("first_valid_cycle", 32'(first_valid), 32'd2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_ready = 1'b0;
    no_of_rows = 8'd0; no_of_columns = 8'd0; scale_shift = 4'd0;
    model_lfsr = 16'hACE1;
    tick();
    tick();
    check("reset_wr_valid", 32'(wr_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    tick();

    vecs[0] = '{2, 3, 0, 0, 0, 0};
    vecs[1] = '{1, 4, 1, 0, 0, 0};
    vecs[2] = '{0, 5, 0, 2, 0, 0};
    vecs[3] = '{3, 3, 0, 4, 0, 0};
    vecs[4] = '{2, 2, 0, 0, 0, 0};
    vecs[5] = '{4, 4, 0, 0, 5, 0};
`ifdef WEIGHT_SCALE_EN
    vecs[6] = '{1, 2, 0, 0, 0, 4};
`else
    vecs[6] = '{1, 1, 0, 0, 0, 0};
`endif
    vecs[7] = '{5, 0, 0, 0, 0, 0};

    for (int k = 0; k < 8; k++) begin
      run(vecs[k]);
      if (k == 0) begin
        check("first_word_seed", 32'(first_d[0]), 32'h0000_ACE1);
        check("second_word", 32'(first_d[1]), 32'h0000_E270);
      end
      if (k == 6) begin
`ifdef WEIGHT_SCALE_EN
        check("scaled_word0", 32'(first_d[0]), 32'h0000_FACE);
        check("scaled_word1", 32'(first_d[1]), 32'h0000_FE27);
`else
        check("seed_after_rst", 32'(first_d[0]), 32'h0000_ACE1);
`endif
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
